// File: rtl/name_record_packer.sv
// Buffers 160-bit name records in a small FIFO and streams each one out as five
// 32-bit words (MSB first) over a valid/ready handshake.
module name_record_packer #(
   parameter int DEPTH     = 4,
   parameter bit DROP_ZERO = 1'b1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [159:0] in_rec,
   input  logic         in_write,
   output logic [31:0]  out_word,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         out_last,
   output logic [4:0]   fifo_level,
   output logic         overflow,
   output logic [31:0]  rec_count
);

   localparam int         PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [4:0] LEVEL_MAX = 5'(DEPTH);

   logic [159:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [4:0]       level_q, level_d;
   logic [2:0]       widx_q, widx_d;
   logic             overflow_q, overflow_d;
   logic [31:0]      rec_count_q, rec_count_d;

   logic             is_zero, full, accept, drop, hs, pop;
   logic [159:0]     head;
   logic [31:0]      head_word;

   always_comb begin
      is_zero     = DROP_ZERO && (in_rec[31:0] == 32'd0);
      full        = (level_q == LEVEL_MAX);
      accept      = in_write && !is_zero && !full;
      // Fullness is judged on the level at the start of the cycle, so a
      // record arriving alongside the final-word pop of a full FIFO is lost.
      drop        = in_write && !is_zero && full;
      hs          = (level_q != 5'd0) && out_ready;
      pop         = hs && (widx_q == 3'd4);

      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      widx_d      = widx_q;
      overflow_d  = overflow_q;
      rec_count_d = rec_count_q;

      if (accept) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (drop)   overflow_d = 1'b1;
      if (hs)     widx_d = pop ? 3'd0 : widx_q + 3'd1;
      if (pop) begin
         rd_ptr_d    = rd_ptr_q + PTR_W'(1);
         rec_count_d = rec_count_q + 32'd1;
      end

      case ({accept, pop})
         2'b10:   level_d = level_q + 5'd1;
         2'b01:   level_d = level_q - 5'd1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         widx_q      <= '0;
         overflow_q  <= 1'b0;
         rec_count_q <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         widx_q      <= widx_d;
         overflow_q  <= overflow_d;
         rec_count_q <= rec_count_d;
      end
   end

   // Record storage carries data only and is never reset.
   always_ff @(posedge clk) begin
      if (accept) mem_q[wr_ptr_q] <= in_rec;
   end

   always_comb begin
      head = mem_q[rd_ptr_q];
      case (widx_q)
         3'd0:    head_word = head[159:128];
         3'd1:    head_word = head[127:96];
         3'd2:    head_word = head[95:64];
         3'd3:    head_word = head[63:32];
         default: head_word = head[31:0];
      endcase
   end

   assign out_valid  = (level_q != 5'd0);
   assign out_word   = out_valid ? head_word : 32'd0;
   assign out_last   = out_valid && (widx_q == 3'd4);
   assign fifo_level = level_q;
   assign overflow   = overflow_q;
   assign rec_count  = rec_count_q;

endmodule

// File: tb/tb_name_record_packer.sv
// Bench for name_record_packer: vector table, hand-written corner sequences,
// and a randomized run against a queue-based reference model.
module tb_name_record_packer;

   logic         clk = 1'b0;
   logic         reset;
   logic [159:0] in_rec;
   logic         in_write;
   logic [31:0]  out_word;
   logic         out_valid;
   logic         out_ready;
   logic         out_last;
   logic [4:0]   fifo_level;
   logic         overflow;
   logic [31:0]  rec_count;

   int checks   = 0;
   int failures = 0;

   name_record_packer #(.DEPTH(4), .DROP_ZERO(1'b1)) dut (
      .clk(clk), .reset(reset), .in_rec(in_rec), .in_write(in_write),
      .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .fifo_level(fifo_level), .overflow(overflow),
      .rec_count(rec_count)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [159:0] rec;
      logic         wr;
      logic         rdy;
      logic [31:0]  word;
      logic         vld;
      logic         last;
      logic [4:0]   lvl;
      logic [31:0]  cnt;
   } vec_t;

   localparam logic [159:0] REC_A = {128'h41424344_45464748_494A4B4C_4D4E4F50, 32'd7};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] wsel(input logic [159:0] r, input int w);
      return r[159-32*w -: 32];
   endfunction

   task automatic do_reset();
      reset = 1'b1; in_write = 1'b0; out_ready = 1'b0; in_rec = '0;
      step();
      step();
      reset = 1'b0;
   endtask

   function automatic logic [159:0] rnd_rec(input bit allow_zero);
      logic [159:0] r;
      r = {$urandom, $urandom, $urandom, $urandom, $urandom};
      if (allow_zero && ($urandom_range(0, 7) == 0)) r[31:0] = 32'd0;
      else if (r[31:0] == 32'd0) r[31:0] = 32'd1;
      return r;
   endfunction

   vec_t          vecs[6];
   logic [159:0]  recs[5];

   // Reference model state
   logic [159:0]  mq[$];
   int            widx_m;
   bit            ovf_m;
   logic [31:0]   rc_m;

   initial begin
      vecs[0] = '{REC_A, 1'b1, 1'b1, 32'h41424344, 1'b1, 1'b0, 5'd1, 32'd0};
      vecs[1] = '{'0,    1'b0, 1'b1, 32'h45464748, 1'b1, 1'b0, 5'd1, 32'd0};
      vecs[2] = '{'0,    1'b0, 1'b1, 32'h494A4B4C, 1'b1, 1'b0, 5'd1, 32'd0};
      vecs[3] = '{'0,    1'b0, 1'b1, 32'h4D4E4F50, 1'b1, 1'b0, 5'd1, 32'd0};
      vecs[4] = '{'0,    1'b0, 1'b1, 32'h00000007, 1'b1, 1'b1, 5'd1, 32'd0};
      vecs[5] = '{'0,    1'b0, 1'b1, 32'h00000000, 1'b0, 1'b0, 5'd0, 32'd1};

      reset = 1'b1; in_write = 1'b0; out_ready = 1'b0; in_rec = '0;
      #2;
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_word", out_word, 32'd0);
      chk("rst_last", {31'd0, out_last}, 32'd0);
      chk("rst_level", {27'd0, fifo_level}, 32'd0);
      chk("rst_ovf", {31'd0, overflow}, 32'd0);
      chk("rst_count", rec_count, 32'd0);
      do_reset();

      // Single record through the vector table
      foreach (vecs[i]) begin
         in_rec = vecs[i].rec; in_write = vecs[i].wr; out_ready = vecs[i].rdy;
         step();
         chk($sformatf("vec%0d_word", i), out_word, vecs[i].word);
         chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].vld});
         chk($sformatf("vec%0d_last", i), {31'd0, out_last}, {31'd0, vecs[i].last});
         chk($sformatf("vec%0d_level", i), {27'd0, fifo_level}, {27'd0, vecs[i].lvl});
         chk($sformatf("vec%0d_count", i), rec_count, vecs[i].cnt);
      end

      // Backpressure holds the first word
      do_reset();
      in_rec = REC_A; in_write = 1'b1; out_ready = 1'b0;
      step();
      in_write = 1'b0;
      for (int c = 0; c < 10; c++) begin
         step();
         chk("bp_hold_word", out_word, 32'h41424344);
         chk("bp_hold_level", {27'd0, fifo_level}, 32'd1);
      end
      out_ready = 1'b1;
      for (int w = 1; w < 5; w++) begin
         step();
         chk($sformatf("bp_word%0d", w), out_word, wsel(REC_A, w));
         chk($sformatf("bp_last%0d", w), {31'd0, out_last}, {31'd0, (w == 4)});
      end
      step();
      chk("bp_empty", {31'd0, out_valid}, 32'd0);

      // Zero-count record is discarded
      do_reset();
      in_rec = {128'hDEAD_BEEF_0000_0000_1111_2222_3333_4444, 32'd0}; in_write = 1'b1;
      step();
      in_write = 1'b0;
      step();
      chk("zero_level", {27'd0, fifo_level}, 32'd0);
      chk("zero_valid", {31'd0, out_valid}, 32'd0);
      chk("zero_ovf", {31'd0, overflow}, 32'd0);

      // Overflow: fifth record is dropped
      do_reset();
      foreach (recs[i]) recs[i] = rnd_rec(1'b0);
      for (int i = 0; i < 5; i++) begin
         in_rec = recs[i]; in_write = 1'b1;
         step();
      end
      in_write = 1'b0;
      chk("ovf_level", {27'd0, fifo_level}, 32'd4);
      chk("ovf_flag", {31'd0, overflow}, 32'd1);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         for (int w = 0; w < 5; w++) begin
            chk($sformatf("ovf_r%0d_w%0d", i, w), out_word, wsel(recs[i], w));
            step();
         end
      end
      chk("ovf_drained", {27'd0, fifo_level}, 32'd0);
      chk("ovf_count", rec_count, 32'd4);
      chk("ovf_sticky", {31'd0, overflow}, 32'd1);

      // Reset in the middle of a record
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_rec = recs[i]; in_write = 1'b1;
         step();
      end
      in_write = 1'b0; out_ready = 1'b1;
      step();
      step();
      out_ready = 1'b0;
      chk("mid_pre_word", out_word, wsel(recs[0], 2));
      #2 reset = 1'b1;
      #1;
      chk("mid_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_word", out_word, 32'd0);
      chk("mid_level", {27'd0, fifo_level}, 32'd0);
      chk("mid_count", rec_count, 32'd0);
      chk("mid_ovf", {31'd0, overflow}, 32'd0);
      @(negedge clk) reset = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("post_rst_idle", {31'd0, out_valid}, 32'd0);
      end
      #2 reset = 1'b1;
      #1;
      in_rec = REC_A; in_write = 1'b1; out_ready = 1'b0;
      reset = 1'b0;
      step();
      in_write = 1'b0;
      chk("first_edge_level", {27'd0, fifo_level}, 32'd1);
      chk("first_edge_word", out_word, 32'h41424344);

      // Store together with the final-word pop
      do_reset();
      recs[0] = rnd_rec(1'b0); recs[1] = rnd_rec(1'b0); recs[2] = rnd_rec(1'b0);
      for (int i = 0; i < 2; i++) begin
         in_rec = recs[i]; in_write = 1'b1;
         step();
      end
      in_write = 1'b0; out_ready = 1'b1;
      for (int w = 0; w < 4; w++) step();
      chk("sim_last_before", {31'd0, out_last}, 32'd1);
      in_rec = recs[2]; in_write = 1'b1;
      step();
      in_write = 1'b0;
      chk("sim_level", {27'd0, fifo_level}, 32'd2);
      for (int i = 1; i < 3; i++) begin
         for (int w = 0; w < 5; w++) begin
            chk($sformatf("sim_r%0d_w%0d", i, w), out_word, wsel(recs[i], w));
            step();
         end
      end
      chk("sim_empty", {27'd0, fifo_level}, 32'd0);
      chk("sim_count", rec_count, 32'd3);

      // Randomized run against the reference model
      do_reset();
      mq.delete(); widx_m = 0; ovf_m = 1'b0; rc_m = 32'd0;
      for (int c = 0; c < 1500; c++) begin
         logic        vld_m;
         logic [31:0] word_m;
         bit          hs_m;
         vld_m  = (mq.size() > 0);
         word_m = vld_m ? wsel(mq[0], widx_m) : 32'd0;
         chk("rnd_word", out_word, word_m);
         chk("rnd_valid", {31'd0, out_valid}, {31'd0, vld_m});
         chk("rnd_last", {31'd0, out_last}, {31'd0, (vld_m && widx_m == 4)});
         chk("rnd_level", {27'd0, fifo_level}, mq.size());
         chk("rnd_ovf", {31'd0, overflow}, {31'd0, ovf_m});
         chk("rnd_count", rec_count, rc_m);

         in_write  = ($urandom_range(0, 9) < 4);
         out_ready = ($urandom_range(0, 9) < 6);
         in_rec    = rnd_rec(1'b1);
         step();

         hs_m = vld_m && out_ready;
         if (in_write && in_rec[31:0] != 32'd0) begin
            if (vld_m && mq.size() >= 4) ovf_m = 1'b1;
            else mq.push_back(in_rec);
         end
         if (hs_m) begin
            if (widx_m == 4) begin
               void'(mq.pop_front());
               widx_m = 0;
               rc_m   = rc_m + 32'd1;
            end else begin
               widx_m++;
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
